prbs_checker: RTL and testbench
===============================

PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 clock  in  1  single clock; all logic on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 rx_bit  in  1  received serial data bit.
REQ-004 rx_valid  in  1  rx_bit qualifier; when low, all state, counters and the LFSR hold.
REQ-005 poly_sel  in  2  0=PRBS7 (x^7+x^6+1), 1=PRBS9 (x^9+x^5+1), 2=PRBS15 (x^15+x^14+1), 3=PRBS23 (x^23+x^18+1).
REQ-006 lock_thresh  in  6  consecutive matching bits needed to declare lock; value 0 is treated as 1.
REQ-007 loss_thresh  in  6  errors within one 64-bit block that force relock; value 0 is treated as 1.
REQ-008 window_len  in  16  bits per measurement window; value 0 is treated as 65536.
REQ-009 clear  in  1  synchronous clear of total_errors only.
REQ-010 locked  out  1  high in LOCKED state.
REQ-011 error  out  1  one-cycle pulse per mismatched bit while LOCKED.
REQ-012 window_errors  out  13  error count of the last completed window.
REQ-013 window_done  out  1  one-cycle pulse when window_errors updates.
REQ-014 total_errors  out  13  cumulative LOCKED errors, saturating.
REQ-015 count  out  16  valid bits checked so far in the current window.

Function
REQ-016 23-bit LFSR s; predicted bit p = s[a-1] XOR s[b-1], with (a,b) = (7,6), (9,5), (15,14), (23,18) per poly_sel.
REQ-017 Each valid bit shifts the LFSR: s <= {s[21:0], f}. In SEED and VERIFY, f = rx_bit; in LOCKED, f = p (free-running, so each channel error counts once).
REQ-018 FSM states SEED, VERIFY, LOCKED. Reset enters SEED.
REQ-019 SEED: shift in N valid bits, where N = polynomial degree (7/9/15/23), then go to VERIFY; no comparisons are made.
REQ-020 VERIFY: on each valid bit, compare rx_bit with p. A match increments the match counter; a mismatch clears it. On the valid bit that brings the count to lock_thresh, enter LOCKED on the next edge.
REQ-021 LOCKED: on each valid bit, rx_bit != p pulses error on the following cycle (registered, latency 1).
REQ-022 LOCKED block monitor: a 6-bit block counter wraps every 64 valid bits. Block errors reach loss_thresh -> return to SEED. The block error count clears at each block wrap.
REQ-023 Entering SEED from LOCKED discards the partial window: count and the window accumulator clear; window_errors and total_errors hold.
REQ-024 Window: count increments per valid bit while LOCKED. On the valid bit where count == window_len-1 (0xFFFF when window_len = 0), the following occur on the next edge:
  - window_errors <= accumulator + this bit's error;
  - window_done pulses;
  - count and accumulator clear.
REQ-025 Accumulator and total_errors saturate at 8191; no wrap.
REQ-026 poly_sel is registered. A change seen while not in SEED forces SEED on the next edge with the seed counter cleared; a change during SEED restarts seeding.
REQ-027 clear and a simultaneous error: total_errors <= 0 (clear wins); the error still counts in the window.
REQ-028 rx_valid low: no pulses on error or window_done; all counters frozen.
REQ-029 window_len or thresholds changed mid-window take effect on the next comparison; no other side effects.

Reset
REQ-030 On reset, the following outputs and states are cleared:
  - state = SEED;
  - s = 0;
  - all counters = 0;
  - locked = 0, error = 0, window_done = 0;
  - window_errors = 0, total_errors = 0, count = 0.
REQ-031 Reset asserted mid-window or mid-lock takes effect at the next edge regardless of rx_valid and aborts all activity.

Verification
REQ-032 Clean PRBS7 stream, rx_valid = 1, lock_thresh = 16 -> locked rises exactly 7+16 valid bits after reset release; error never pulses.
REQ-033 Locked PRBS15, window_len = 1000, 3 single-bit flips injected at bits 100/200/300 of a window -> three error pulses, each 1 cycle after its flipped bit; window_done with window_errors = 3; total_errors = 3.
REQ-034 Locked PRBS23, loss_thresh = 4, 4 flips within one 64-bit block -> locked falls on the edge after the 4th flip; count = 0; relock after 23+lock_thresh clean bits.
REQ-035 Locked PRBS9, rx_valid toggled 50% -> count advances only on valid cycles; window completes after window_len valid bits.
REQ-036 poly_sel switched 0->2 while locked -> SEED next edge; relock onto a PRBS15 stream; no errors are counted during reacquisition.
REQ-037 Saturation: 9000 forced errors with loss_thresh = 63 and an every-other-bit error pattern -> total_errors holds at 8191; clear -> 0 next edge.

Source files
------------

// File: rtl/prbs_checker.sv
// PRBS7/9/15/23 receive checker: self-seeds from the incoming stream, verifies lock,
// then free-runs and counts bit errors per window, per 64-bit block and in total.
//
// state  | meaning
// SEED   | loading the LFSR with the first N received bits, no comparisons
// VERIFY | counting consecutive matches towards lock_thresh
// LOCKED | LFSR free-runs; errors counted, block monitor may force relock
module prbs_checker (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_rx_bit,
    input  logic        i_rx_valid,
    input  logic [1:0]  i_poly_sel,
    input  logic [5:0]  i_lock_thresh,
    input  logic [5:0]  i_loss_thresh,
    input  logic [15:0] i_window_len,
    input  logic        i_clear,
    output logic        o_locked,
    output logic        o_error,
    output logic [12:0] o_window_errors,
    output logic        o_window_done,
    output logic [12:0] o_total_errors,
    output logic [15:0] o_count
);

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [12:0] SAT_MAX = 13'h1FFF;

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_poly;
    logic [22:0] r_lfsr;
    logic [4:0]  r_seed_cnt;
    logic [5:0]  r_match_cnt;
    logic [5:0]  r_blk_cnt;
    logic [5:0]  r_blk_err;
    logic [15:0] r_count;
    logic [12:0] r_acc;
    logic [12:0] r_win_err;
    logic [12:0] r_total;
    logic        r_error;
    logic        r_win_done;

    logic        w_poly_chg;
    logic        w_pred;
    logic        w_mismatch;
    logic [4:0]  w_degree;
    logic        w_seed_last;
    logic [5:0]  w_lock_thr;
    logic [5:0]  w_loss_thr;
    logic        w_match_hit;
    logic        w_bit_locked;
    logic        w_err_bit;
    logic        w_loss;
    logic [15:0] w_wlen_m1;
    logic        w_win_end;
    logic [12:0] w_acc_next;

    always_comb begin
        w_degree = 5'd7;
        w_pred   = r_lfsr[6] ^ r_lfsr[5];
        case (r_poly)
            2'd1: begin
                w_degree = 5'd9;
                w_pred   = r_lfsr[8] ^ r_lfsr[4];
            end
            2'd2: begin
                w_degree = 5'd15;
                w_pred   = r_lfsr[14] ^ r_lfsr[13];
            end
            2'd3: begin
                w_degree = 5'd23;
                w_pred   = r_lfsr[22] ^ r_lfsr[17];
            end
            default: begin
                w_degree = 5'd7;
                w_pred   = r_lfsr[6] ^ r_lfsr[5];
            end
        endcase
    end

    assign w_poly_chg   = (i_poly_sel != r_poly);
    assign w_mismatch   = i_rx_bit ^ w_pred;
    assign w_seed_last  = (r_seed_cnt == (w_degree - 5'd1));
    assign w_lock_thr   = (i_lock_thresh == 6'd0) ? 6'd1 : i_lock_thresh;
    assign w_loss_thr   = (i_loss_thresh == 6'd0) ? 6'd1 : i_loss_thresh;
    assign w_match_hit  = (({1'b0, r_match_cnt} + 7'd1) >= {1'b0, w_lock_thr});
    // A poly_sel change pre-empts the bit presented on the same cycle.
    assign w_bit_locked = i_rx_valid & (r_state == LOCKED) & ~w_poly_chg;
    assign w_err_bit    = w_bit_locked & w_mismatch;
    assign w_loss       = w_err_bit & (({1'b0, r_blk_err} + 7'd1) >= {1'b0, w_loss_thr});
    assign w_wlen_m1    = i_window_len - 16'd1;
    assign w_win_end    = w_bit_locked & (r_count == w_wlen_m1);
    assign w_acc_next   = (r_acc == SAT_MAX) ? SAT_MAX : (r_acc + {12'd0, w_mismatch});

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= SEED;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_poly_chg) begin
            w_state_next = SEED;
        end else if (i_rx_valid) begin
            case (r_state)
                SEED:    if (w_seed_last) w_state_next = VERIFY;
                VERIFY:  if (!w_mismatch && w_match_hit) w_state_next = LOCKED;
                LOCKED:  if (w_loss) w_state_next = SEED;
                default: w_state_next = SEED;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_poly      <= i_poly_sel;
            r_lfsr      <= '0;
            r_seed_cnt  <= '0;
            r_match_cnt <= '0;
            r_blk_cnt   <= '0;
            r_blk_err   <= '0;
            r_count     <= '0;
            r_acc       <= '0;
            r_win_err   <= '0;
            r_total     <= '0;
            r_error     <= 1'b0;
            r_win_done  <= 1'b0;
        end else begin
            r_poly     <= i_poly_sel;
            r_error    <= w_err_bit;
            r_win_done <= w_win_end & ~w_loss;

            if (i_clear) begin
                r_total <= '0;
            end else if (w_err_bit && (r_total != SAT_MAX)) begin
                r_total <= r_total + 13'd1;
            end

            // Restart acquisition: the partial window is dropped, results are kept.
            if (w_poly_chg || w_loss) begin
                r_seed_cnt  <= '0;
                r_match_cnt <= '0;
                r_blk_cnt   <= '0;
                r_blk_err   <= '0;
                r_count     <= '0;
                r_acc       <= '0;
            end else if (i_rx_valid) begin
                case (r_state)
                    SEED: begin
                        r_lfsr     <= {r_lfsr[21:0], i_rx_bit};
                        r_seed_cnt <= w_seed_last ? 5'd0 : (r_seed_cnt + 5'd1);
                    end
                    VERIFY: begin
                        r_lfsr      <= {r_lfsr[21:0], i_rx_bit};
                        r_match_cnt <= (w_mismatch || w_match_hit) ? 6'd0 : (r_match_cnt + 6'd1);
                    end
                    LOCKED: begin
                        r_lfsr    <= {r_lfsr[21:0], w_pred};
                        r_blk_cnt <= r_blk_cnt + 6'd1;
                        r_blk_err <= (r_blk_cnt == 6'd63) ? 6'd0 : (r_blk_err + {5'd0, w_mismatch});
                        if (w_win_end) begin
                            r_win_err <= w_acc_next;
                            r_count   <= '0;
                            r_acc     <= '0;
                        end else begin
                            r_count <= r_count + 16'd1;
                            r_acc   <= w_acc_next;
                        end
                    end
                    default: begin
                        r_lfsr <= r_lfsr;
                    end
                endcase
            end
        end
    end

    assign o_locked        = (r_state == LOCKED);
    assign o_error         = r_error;
    assign o_window_errors = r_win_err;
    assign o_window_done   = r_win_done;
    assign o_total_errors  = r_total;
    assign o_count         = r_count;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: a bit-history reference model checked every cycle, plus
// directed scenarios with hand-derived lock latencies, error counts and saturation values.
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_bit = 1'b0;
    logic        rx_valid = 1'b0;
    logic [1:0]  poly_sel = 2'd0;
    logic [5:0]  lock_thresh = 6'd16;
    logic [5:0]  loss_thresh = 6'd4;
    logic [15:0] window_len = 16'd1000;
    logic        clear = 1'b0;
    logic        o_locked;
    logic        o_error;
    logic [12:0] o_window_errors;
    logic        o_window_done;
    logic [12:0] o_total_errors;
    logic [15:0] o_count;

    prbs_checker dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_rx_bit        (rx_bit),
        .i_rx_valid      (rx_valid),
        .i_poly_sel      (poly_sel),
        .i_lock_thresh   (lock_thresh),
        .i_loss_thresh   (loss_thresh),
        .i_window_len    (window_len),
        .i_clear         (clear),
        .o_locked        (o_locked),
        .o_error         (o_error),
        .o_window_errors (o_window_errors),
        .o_window_done   (o_window_done),
        .o_total_errors  (o_total_errors),
        .o_count         (o_count)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad = 0;
    int err_pulses = 0;
    bit chk_on = 1'b0;

    // expected outputs after the most recent edge
    bit exp_locked, exp_error, exp_wdone;
    int exp_werr, exp_total, exp_count;

    // model: hist[0] is the newest bit held by the receiver's predictor
    int hist[$];
    int m_poly;
    bit m_locked;
    int m_heard, m_run, m_blk_pos, m_blk_err, m_wacc;

    // transmitter
    int txh[$];
    int tx_poly = 0;

    task automatic chk(input string name, input int act, input int req);
        n_total++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("locked",        int'(o_locked),        int'(exp_locked));
            chk("error",         int'(o_error),         int'(exp_error));
            chk("window_done",   int'(o_window_done),   int'(exp_wdone));
            chk("window_errors", int'(o_window_errors), exp_werr);
            chk("total_errors",  int'(o_total_errors),  exp_total);
            chk("count",         int'(o_count),         exp_count);
            if (o_error) err_pulses++;
        end
    end

    function automatic int tap_a(input int p);
        case (p)
            1: return 9;
            2: return 15;
            3: return 23;
            default: return 7;
        endcase
    endfunction

    function automatic int tap_b(input int p);
        case (p)
            1: return 5;
            2: return 14;
            3: return 18;
            default: return 6;
        endcase
    endfunction

    function automatic int sat(input int v);
        return (v > 8191) ? 8191 : v;
    endfunction

    function automatic bit tx_next();
        int nb;
        nb = txh[tap_a(tx_poly) - 1] ^ txh[tap_b(tx_poly) - 1];
        txh.push_front(nb);
        void'(txh.pop_back());
        return bit'(nb);
    endfunction

    task automatic restart();
        m_locked  = 1'b0;
        m_heard   = 0;
        m_run     = 0;
        m_blk_pos = 0;
        m_blk_err = 0;
        m_wacc    = 0;
        exp_count = 0;
    endtask

    task automatic model_step(input bit rs, input bit v, input bit b, input bit cl,
                              input int ps, input int lt, input int lo, input int wl);
        int a, bb, p, lthr, lothr, wlen;
        bit err;
        exp_error = 1'b0;
        exp_wdone = 1'b0;
        err = 1'b0;
        if (rs) begin
            hist.delete();
            repeat (23) hist.push_back(0);
            m_poly = ps;
            restart();
            exp_werr  = 0;
            exp_total = 0;
            exp_locked = 1'b0;
            return;
        end
        a     = tap_a(m_poly);
        bb    = tap_b(m_poly);
        lthr  = (lt == 0) ? 1 : lt;
        lothr = (lo == 0) ? 1 : lo;
        wlen  = (wl == 0) ? 65536 : wl;
        if (ps != m_poly) begin
            m_poly = ps;
            restart();
        end else if (v) begin
            p = hist[a - 1] ^ hist[bb - 1];
            if (!m_locked) begin
                if (m_heard < a) begin
                    m_heard++;
                end else begin
                    if (int'(b) == p) m_run++;
                    else m_run = 0;
                    if (m_run >= lthr) begin
                        m_locked = 1'b1;
                        m_run = 0;
                    end
                end
                hist.push_front(int'(b));
            end else begin
                err = (int'(b) != p);
                exp_error = err;
                hist.push_front(p);
                m_blk_err += int'(err);
                if (err && (m_blk_err >= lothr)) begin
                    restart();
                end else begin
                    m_blk_pos = (m_blk_pos + 1) % 64;
                    if (m_blk_pos == 0) m_blk_err = 0;
                    if (exp_count == wlen - 1) begin
                        exp_werr  = sat(m_wacc + int'(err));
                        exp_wdone = 1'b1;
                        exp_count = 0;
                        m_wacc    = 0;
                    end else begin
                        exp_count++;
                        m_wacc = sat(m_wacc + int'(err));
                    end
                end
            end
            void'(hist.pop_back());
        end
        if (cl) exp_total = 0;
        else if (err) exp_total = sat(exp_total + 1);
        exp_locked = m_locked;
    endtask

    // one clock: drive after the falling edge, outputs readable #1 after the rising edge
    task automatic cyc(input bit v, input bit b, input bit cl);
        @(negedge clk);
        #1;
        rx_valid = v;
        rx_bit   = b;
        clear    = cl;
        model_step(rst, v, b, cl, int'(poly_sel), int'(lock_thresh), int'(loss_thresh), int'(window_len));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        chk_on = 1'b1;
    endtask

    task automatic wait_lock(output int n);
        n = 0;
        while (!o_locked && n < 300) begin
            cyc(1'b1, tx_next(), 1'b0);
            n++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, nv, k, p0;
        bit b;
        bit done;
        repeat (23) txh.push_back(1);

        // reset state and clean PRBS7 lock latency
        poly_sel = 2'd0; tx_poly = 0; lock_thresh = 6'd16;
        do_reset();
        chk("reset_locked", int'(o_locked), 0);
        chk("reset_count", int'(o_count), 0);
        chk("reset_total", int'(o_total_errors), 0);
        chk("reset_werr", int'(o_window_errors), 0);
        chk("reset_error", int'(o_error), 0);
        chk("reset_wdone", int'(o_window_done), 0);
        wait_lock(n);
        chk("prbs7_lock_bits", n, 7 + 16);
        repeat (100) cyc(1'b1, tx_next(), 1'b0);
        chk("prbs7_no_errors", err_pulses, 0);

        // lock_thresh = 0 behaves as 1
        poly_sel = 2'd1; tx_poly = 1; lock_thresh = 6'd0;
        do_reset();
        wait_lock(n);
        chk("prbs9_thresh0_lock_bits", n, 9 + 1);

        // PRBS15 window of 1000 with three flips
        poly_sel = 2'd2; tx_poly = 2; lock_thresh = 6'd16; loss_thresh = 6'd4; window_len = 16'd1000;
        do_reset();
        wait_lock(n);
        chk("prbs15_lock_bits", n, 15 + 16);
        p0 = err_pulses;
        for (int i = 0; i < 1000; i++) begin
            b = tx_next();
            if (i == 100 || i == 200 || i == 300) b = ~b;
            cyc(1'b1, b, 1'b0);
            if (i == 100 || i == 200 || i == 300) chk("flip_error_pulse", int'(o_error), 1);
        end
        chk("window_done_1000", int'(o_window_done), 1);
        chk("window_errors_3", int'(o_window_errors), 3);
        chk("total_errors_3", int'(o_total_errors), 3);
        chk("error_pulse_count_3", err_pulses - p0, 3);

        // PRBS23 loss of lock after 4 errors in one block, then relock
        poly_sel = 2'd3; tx_poly = 3; lock_thresh = 6'd8; loss_thresh = 6'd4; window_len = 16'd1000;
        do_reset();
        wait_lock(n);
        chk("prbs23_lock_bits", n, 23 + 8);
        repeat (20) cyc(1'b1, tx_next(), 1'b0);
        for (int i = 0; i < 12; i++) begin
            b = tx_next();
            if (i % 3 == 2) b = ~b;
            cyc(1'b1, b, 1'b0);
            if (i == 8) chk("still_locked_after_3", int'(o_locked), 1);
        end
        chk("unlocked_after_4", int'(o_locked), 0);
        chk("count_cleared_on_loss", int'(o_count), 0);
        wait_lock(n);
        chk("prbs23_relock_bits", n, 23 + 8);

        // PRBS9 with rx_valid toggling: window needs window_len valid bits
        poly_sel = 2'd1; tx_poly = 1; lock_thresh = 6'd10; window_len = 16'd100;
        do_reset();
        wait_lock(n);
        nv = 0; k = 0; done = 1'b0;
        while (!done && k < 500) begin
            if (k % 2 == 0) begin
                cyc(1'b1, tx_next(), 1'b0);
                nv++;
            end else begin
                cyc(1'b0, bit'($urandom_range(0, 1)), 1'b0);
            end
            if (o_window_done) done = 1'b1;
            k++;
        end
        chk("toggle_window_valid_bits", nv, 100);
        chk("toggle_window_errors", int'(o_window_errors), 0);

        // poly_sel 0 -> 2 while locked
        poly_sel = 2'd0; tx_poly = 0; lock_thresh = 6'd16; window_len = 16'd1000;
        do_reset();
        wait_lock(n);
        repeat (30) cyc(1'b1, tx_next(), 1'b0);
        poly_sel = 2'd2;
        cyc(1'b0, 1'b0, 1'b0);
        chk("poly_switch_unlocks", int'(o_locked), 0);
        tx_poly = 2;
        p0 = err_pulses;
        wait_lock(n);
        chk("poly_switch_relock_bits", n, 15 + 16);
        chk("poly_switch_total", int'(o_total_errors), 0);
        chk("poly_switch_pulses", err_pulses - p0, 0);

        // saturation with alternating errors, then clear racing an error
        poly_sel = 2'd0; tx_poly = 0; lock_thresh = 6'd4; loss_thresh = 6'd63; window_len = 16'd0;
        do_reset();
        wait_lock(n);
        for (int i = 0; i < 18000; i++) begin
            b = tx_next();
            if (i % 2 == 0) b = ~b;
            cyc(1'b1, b, 1'b0);
        end
        chk("saturated_total", int'(o_total_errors), 8191);
        chk("still_locked_alt", int'(o_locked), 1);
        cyc(1'b1, ~tx_next(), 1'b1);
        chk("clear_wins_total", int'(o_total_errors), 0);
        chk("clear_error_pulse", int'(o_error), 1);
        cyc(1'b1, tx_next(), 1'b0);
        cyc(1'b1, ~tx_next(), 1'b0);
        chk("total_after_clear", int'(o_total_errors), 1);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
